cmd_dvb_arb: RTL and testbench

- Arbitrates byte-serial DVB command frames from N independent requesters onto the single cmd_dvb command stream; one frame = one contiguous run of en-high bytes.
- Each requester port has its own frame-buffering FIFO, because sources cannot be back-pressured. Only complete frames are granted, round-robin, and each is replayed as one contiguous burst.
- The returning response frame is routed to the requester that owns the outstanding command.
- Sits in the clk_main domain between command sources (PCIe DMA command path, local control) and the DVB command interface.

---
 rtl/cmd_dvb_pkg.sv | 16 +
 rtl/cmd_byte_fifo.sv | 92 +++++++++
 rtl/cmd_dvb_arb.sv | 151 +++++++++++++++
 tb/tb_cmd_dvb_arb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_dvb_pkg.sv
// Shared types and constants for the DVB command arbiter.
// Entries carry a frame-end marker above the data byte.
package cmd_dvb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_SEND,
        ST_GAP,
        ST_WAIT_RSP
    } state_e;

    localparam int ENTRY_W = 9;
    localparam int GAP_MIN = 3;

endpackage

// File: rtl/cmd_byte_fifo.sv
// Per-requester frame FIFO: stores {last,data}, counts complete frames
// and rewinds an overflowing frame back to its first byte.
module cmd_byte_fifo
    import cmd_dvb_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic               clk_main,
    input  logic               rst_n,
    input  logic [7:0]         din,
    input  logic               din_en,
    input  logic               rd,
    input  logic               frm_pop,
    output logic [ENTRY_W-1:0] dout,
    output logic               frm_avail,
    output logic               ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW:0]        wr_q, rd_q, start_q;
    logic [7:0]         hold_q;
    logic               hold_vld_q;
    logic               drop_q;
    logic [AW-1:0]      frm_cnt_q;
    logic               ovf_q;
    logic [ENTRY_W-1:0] dout_q;

    logic full, last, wr_try, wr_ok, wr_ovf, frm_inc;

    always_comb begin
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        last    = ~din_en;
        wr_try  = hold_vld_q && !drop_q;
        wr_ok   = wr_try && !full;
        wr_ovf  = wr_try && full;
        frm_inc = wr_ok && last;
    end

    always_ff @(posedge clk_main) begin
        if (wr_ok) begin
            mem[wr_q[AW-1:0]] <= {last, hold_q};
        end
    end

    always_ff @(posedge clk_main) begin
        if (!rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            start_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            drop_q     <= 1'b0;
            frm_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            dout_q     <= '0;
        end else begin
            hold_q     <= din;
            hold_vld_q <= din_en;
            if (wr_ok) begin
                wr_q <= wr_q + 1'b1;
                if (last) begin
                    start_q <= wr_q + 1'b1;
                end
            end else if (wr_ovf) begin
                wr_q  <= start_q;
                ovf_q <= 1'b1;
            end
            // Discard the tail of an overflowed frame up to its end marker
            if (wr_ovf && !last) begin
                drop_q <= 1'b1;
            end else if (drop_q && hold_vld_q && last) begin
                drop_q <= 1'b0;
            end
            if (rd) begin
                dout_q <= mem[rd_q[AW-1:0]];
                rd_q   <= rd_q + 1'b1;
            end
            if (frm_inc && !frm_pop) begin
                frm_cnt_q <= frm_cnt_q + 1'b1;
            end else if (!frm_inc && frm_pop) begin
                frm_cnt_q <= frm_cnt_q - 1'b1;
            end
        end
    end

    assign dout      = dout_q;
    assign frm_avail = (frm_cnt_q != '0);
    assign ovf       = ovf_q;

endmodule

// File: rtl/cmd_dvb_arb.sv
// Round-robin arbiter replaying complete command frames onto cmd_dvb
// and routing the response back to the owner of the command.
module cmd_dvb_arb
    import cmd_dvb_pkg::*;
#(
    parameter int N       = 2,
    parameter int DEPTH   = 512,
    parameter int GAP_CYC = 4,
    parameter int TMO     = 65535
) (
    input  logic           clk_main,
    input  logic           rst_n,
    input  logic [8*N-1:0] req_din,
    input  logic [N-1:0]   req_din_en,
    output logic [7:0]     cmd_dout,
    output logic           cmd_dout_en,
    input  logic [7:0]     rsp_din,
    input  logic           rsp_din_en,
    output logic [7:0]     rsp_dout,
    output logic [N-1:0]   rsp_dout_en,
    output logic [N-1:0]   ovf,
    output logic           busy
);

    localparam int GAP_N = (GAP_CYC < GAP_MIN) ? GAP_MIN : GAP_CYC;
    localparam int PW    = (N > 1) ? $clog2(N) : 1;

    logic [ENTRY_W-1:0] f_dout [N];
    logic [N-1:0]       f_avail, f_ovf, f_rd, f_pop;

    for (genvar g = 0; g < N; g++) begin : g_fifo
        cmd_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk_main  (clk_main),
            .rst_n     (rst_n),
            .din       (req_din[8*g +: 8]),
            .din_en    (req_din_en[g]),
            .rd        (f_rd[g]),
            .frm_pop   (f_pop[g]),
            .dout      (f_dout[g]),
            .frm_avail (f_avail[g]),
            .ovf       (f_ovf[g])
        );
    end

    state_e             state_q;
    logic [PW-1:0]      rr_q, own_q, pick;
    logic [15:0]        cnt_q;
    logic [7:0]         cmd_dout_q, rsp_dout_q;
    logic               cmd_en_q, rsp_in_q;
    logic [N-1:0]       rsp_oh_q, own_oh;
    logic [ENTRY_W-1:0] cur;
    int                 idx;
    logic               found;

    always_comb begin
        pick  = rr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(rr_q) + i) % N;
            if (!found && f_avail[idx]) begin
                pick  = PW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        cur    = f_dout[own_q];
        own_oh = {{(N-1){1'b0}}, 1'b1} << own_q;
        f_rd   = '0;
        f_pop  = '0;
        if (state_q == ST_GRANT) begin
            f_rd[own_q] = 1'b1;
        end
        // In SEND the entry read last cycle is on cur; stop reading at its end
        if (state_q == ST_SEND) begin
            if (cur[ENTRY_W-1]) f_pop[own_q] = 1'b1;
            else                f_rd[own_q]  = 1'b1;
        end
    end

    always_ff @(posedge clk_main) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_q       <= PW'(N-1);
            own_q      <= '0;
            cnt_q      <= '0;
            cmd_dout_q <= '0;
            cmd_en_q   <= 1'b0;
            rsp_dout_q <= '0;
            rsp_oh_q   <= '0;
            rsp_in_q   <= 1'b0;
        end else begin
            cmd_en_q   <= (state_q == ST_SEND);
            cmd_dout_q <= (state_q == ST_SEND) ? cur[7:0] : 8'h00;
            rsp_in_q   <= rsp_din_en;
            if (state_q == ST_WAIT_RSP) begin
                rsp_dout_q <= rsp_din;
                rsp_oh_q   <= own_oh & {N{rsp_din_en}};
            end else begin
                rsp_dout_q <= '0;
                rsp_oh_q   <= '0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (|f_avail) begin
                        state_q <= ST_GRANT;
                        own_q   <= pick;
                        rr_q    <= pick;
                    end
                end
                ST_GRANT: state_q <= ST_SEND;
                ST_SEND: begin
                    if (cur[ENTRY_W-1]) begin
                        state_q <= ST_GAP;
                        cnt_q   <= '0;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == 16'(GAP_N-1)) begin
                        state_q <= ST_WAIT_RSP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT_RSP: begin
                    if (rsp_in_q && !rsp_din_en) begin
                        state_q <= ST_IDLE;
                    end else if (rsp_din_en) begin
                        cnt_q <= '0;
                    end else if (cnt_q == 16'(TMO-1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_dout    = cmd_dout_q;
    assign cmd_dout_en = cmd_en_q;
    assign rsp_dout    = rsp_dout_q;
    assign rsp_dout_en = rsp_oh_q;
    assign ovf         = f_ovf;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cmd_dvb_arb.sv
// Scoreboard bench for cmd_dvb_arb: stimulus pushes expected bytes,
// frame lengths and responses; a negedge monitor pops and compares.
module tb_cmd_dvb_arb;

    localparam int N     = 2;
    localparam int DEPTH = 16;
    localparam int GAP   = 4;
    localparam int TMO   = 100;

    logic           clk_main = 1'b0;
    logic           rst_n;
    logic [8*N-1:0] req_din;
    logic [N-1:0]   req_din_en;
    logic [7:0]     cmd_dout;
    logic           cmd_dout_en;
    logic [7:0]     rsp_din;
    logic           rsp_din_en;
    logic [7:0]     rsp_dout;
    logic [N-1:0]   rsp_dout_en;
    logic [N-1:0]   ovf;
    logic           busy;

    always #5 clk_main = ~clk_main;

    cmd_dvb_arb #(.N(N), .DEPTH(DEPTH), .GAP_CYC(GAP), .TMO(TMO)) dut (
        .clk_main    (clk_main),
        .rst_n       (rst_n),
        .req_din     (req_din),
        .req_din_en  (req_din_en),
        .cmd_dout    (cmd_dout),
        .cmd_dout_en (cmd_dout_en),
        .rsp_din     (rsp_din),
        .rsp_din_en  (rsp_din_en),
        .rsp_dout    (rsp_dout),
        .rsp_dout_en (rsp_dout_en),
        .ovf         (ovf),
        .busy        (busy)
    );

    int           nvec = 0;
    int           nerr = 0;
    logic [7:0]   exp_cmd [$];
    int           exp_len [$];
    logic [N+7:0] exp_rsp [$];
    int           run  = 0;
    int           idle = 99;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_main);
        #1;
    endtask

    task automatic exp_frame(int len, int base);
        for (int i = 0; i < len; i++) exp_cmd.push_back(8'(base + i));
        exp_len.push_back(len);
    endtask

    task automatic send(int p, int len, int base);
        for (int i = 0; i < len; i++) begin
            tick();
            req_din[8*p +: 8] = 8'(base + i);
            req_din_en[p]     = 1'b1;
        end
        tick();
        req_din[8*p +: 8] = 8'h00;
        req_din_en[p]     = 1'b0;
    endtask

    task automatic send_pair(int l0, int b0, int l1, int b1);
        int mx;
        mx = (l0 > l1) ? l0 : l1;
        for (int i = 0; i < mx; i++) begin
            tick();
            req_din_en[0] = (i >= mx - l0);
            req_din[7:0]  = (i >= mx - l0) ? 8'(b0 + i - (mx - l0)) : 8'h00;
            req_din_en[1] = (i >= mx - l1);
            req_din[15:8] = (i >= mx - l1) ? 8'(b1 + i - (mx - l1)) : 8'h00;
        end
        tick();
        req_din    = '0;
        req_din_en = '0;
    endtask

    task automatic wait_en(logic lvl, string nm);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_main);
            if (cmd_dout_en == lvl) break;
        end
        chk(nm, 32'(cmd_dout_en), 32'(lvl));
    endtask

    task automatic drain(string nm);
        for (int i = 0; i < 800; i++) begin
            @(negedge clk_main);
            if (exp_len.size() == 0 && !busy) break;
        end
        chk(nm, 32'(exp_len.size() == 0 && !busy), 32'd1);
    endtask

    always @(negedge clk_main) begin
        if (!rst_n) begin
            run  = 0;
            idle = 99;
        end else begin
            if (cmd_dout_en) begin
                if (run == 0) chk("gap_before_frame", 32'(idle >= GAP), 32'd1);
                run++;
                idle = 0;
                if (exp_cmd.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_cmd: got %0h want none", cmd_dout);
                end else begin
                    chk("cmd_byte", 32'(cmd_dout), 32'(exp_cmd.pop_front()));
                end
            end else begin
                chk("cmd_idle_zero", 32'(cmd_dout), 32'd0);
                if (run > 0) begin
                    if (exp_len.size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL unexpected_frame: got len %0d want none", run);
                    end else begin
                        chk("frame_len", 32'(run), 32'(exp_len.pop_front()));
                    end
                    run = 0;
                end
                idle++;
            end
            if (rsp_dout_en !== '0) begin
                if (exp_rsp.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_rsp: got %0h want none", rsp_dout_en);
                end else begin
                    chk("rsp", 32'({rsp_dout_en, rsp_dout}), 32'(exp_rsp.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n      = 1'b0;
        req_din    = '0;
        req_din_en = '0;
        rsp_din    = '0;
        rsp_din_en = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk_main);
        chk("rst_cmd_en", 32'(cmd_dout_en), 32'd0);
        chk("rst_cmd", 32'(cmd_dout), 32'd0);
        chk("rst_rsp_en", 32'(rsp_dout_en), 32'd0);
        chk("rst_rsp", 32'(rsp_dout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Response while idle is dropped
        for (int i = 0; i < 3; i++) begin
            tick();
            rsp_din    = 8'(8'hE0 + i);
            rsp_din_en = 1'b1;
            @(negedge clk_main);
            chk("unsol_rsp_en", 32'(rsp_dout_en), 32'd0);
        end
        tick();
        rsp_din    = 8'h00;
        rsp_din_en = 1'b0;
        @(negedge clk_main);
        chk("unsol_rsp_en", 32'(rsp_dout_en), 32'd0);

        // Same-cycle completion, rr starts at N-1: port 0 first
        exp_frame(4, 'h10);
        exp_frame(6, 'h20);
        send_pair(4, 'h10, 6, 'h20);
        drain("pairA_done");

        // Single frame with a 3-byte response to port 0
        exp_frame(5, 'h01);
        send(0, 5, 'h01);
        wait_en(1'b1, "single_en_hi");
        wait_en(1'b0, "single_en_lo");
        repeat (5) tick();
        exp_rsp.push_back({2'b01, 8'hAA});
        exp_rsp.push_back({2'b01, 8'hBB});
        exp_rsp.push_back({2'b01, 8'hCC});
        rsp_din_en = 1'b1;
        rsp_din    = 8'hAA;
        tick();
        rsp_din    = 8'hBB;
        tick();
        rsp_din    = 8'hCC;
        tick();
        rsp_din_en = 1'b0;
        rsp_din    = 8'h00;
        drain("single_done");
        chk("rsp_drained", 32'(exp_rsp.size()), 32'd0);

        // Last grant was port 0, so port 1 wins this time
        exp_frame(6, 'h40);
        exp_frame(4, 'h30);
        send_pair(4, 'h30, 6, 'h40);
        drain("pairB_done");

        // Overflow on port 1, then an intact frame
        send(1, 20, 'h90);
        repeat (4) @(negedge clk_main);
        chk("ovf_set", 32'(ovf), 32'd2);
        chk("ovf_no_grant", 32'(busy), 32'd0);
        exp_frame(3, 'h50);
        send(1, 3, 'h50);
        drain("post_ovf_done");
        chk("ovf_sticky", 32'(ovf), 32'd2);

        // 1-byte frame, no response: timeout
        exp_frame(1, 'h7E);
        send(0, 1, 'h7E);
        wait_en(1'b1, "one_en_hi");
        wait_en(1'b0, "one_en_lo");
        k = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_main);
            k++;
            if (!busy) break;
        end
        chk("tmo_cycles", 32'(k), 32'd103);
        tick();
        rsp_din    = 8'h55;
        rsp_din_en = 1'b1;
        tick();
        rsp_din_en = 1'b0;
        rsp_din    = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_main);
            chk("late_rsp_en", 32'(rsp_dout_en), 32'd0);
        end

        // Reset mid-SEND with another frame pending
        exp_frame(8, 'h60);
        send(0, 8, 'h60);
        send(1, 3, 'h70);
        wait_en(1'b1, "rst_send_hi");
        repeat (2) @(negedge clk_main);
        tick();
        rst_n = 1'b0;
        exp_cmd.delete();
        exp_len.delete();
        tick();
        rst_n = 1'b1;
        @(negedge clk_main);
        chk("rst_mid_en", 32'(cmd_dout_en), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ovf", 32'(ovf), 32'd0);
        repeat (30) @(negedge clk_main);
        chk("rst_fifos_empty", 32'(busy), 32'd0);
        exp_frame(5, 'h80);
        send(1, 5, 'h80);
        drain("post_rst_done");

        chk("cmd_q_empty", 32'(exp_cmd.size()), 32'd0);
        chk("rsp_q_empty", 32'(exp_rsp.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
